// File: rtl/led_fade_pkg.sv
// ---------------------------------------------------------------------------
// led_fade_pkg
// Shared definitions for the LED fade sequencer:
//   N_CH_DEF  - default number of LED channels
//   PWM_W_DEF - default brightness / PWM counter width
//   RATE_W    - width of the per-channel fade-rate field
//   state_e   - sequencer FSM states (IDLE, SCAN)
// ---------------------------------------------------------------------------
package led_fade_pkg;

  localparam int N_CH_DEF  = 8;
  localparam int PWM_W_DEF = 10;
  localparam int RATE_W    = 4;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

endpackage : led_fade_pkg

// File: rtl/led_pwm_core.sv
// ---------------------------------------------------------------------------
// led_pwm_core
// Free-running PWM counter plus one registered comparator per channel.
// A channel output is high while the counter is below its effective level,
// so level 0 is constantly off and the top level is off for one count only.
// Ports:
//   clk_25mhz - clock
//   rst       - asynchronous active-high reset (counter and outputs to 0)
//   eff       - effective brightness per channel
//   led       - registered PWM outputs, one cycle behind the comparison
// ---------------------------------------------------------------------------
module led_pwm_core #(
  parameter int N_CH  = 8,
  parameter int PWM_W = 10
) (
  input  logic                        clk_25mhz,
  input  logic                        rst,
  input  logic [N_CH-1:0][PWM_W-1:0]  eff,
  output logic [N_CH-1:0]             led
);

  logic [PWM_W-1:0] pwm_ctr_r;
  logic [N_CH-1:0]  led_r;

  // PWM counter: free-running, wraps naturally at 2^PWM_W.
  always_ff @(posedge clk_25mhz or posedge rst) begin
    if (rst) begin
      pwm_ctr_r <= '0;
    end else begin
      pwm_ctr_r <= pwm_ctr_r + PWM_W'(1);
    end
  end

  // Per-channel registered comparators.
  always_ff @(posedge clk_25mhz or posedge rst) begin
    if (rst) begin
      led_r <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        led_r[i] <= (pwm_ctr_r < eff[i]);
      end
    end
  end

  assign led = led_r;

endmodule : led_pwm_core

// File: rtl/led_fade_sequencer.sv
// ---------------------------------------------------------------------------
// led_fade_sequencer
// Multi-channel LED fader. A prescaler produces a fade tick every STEP_DIV
// clocks (frozen while pause is high). On each tick the FSM scans all
// channels, one per cycle, moving each current brightness towards its target
// by (rate+1) units and clamping at the target. Commands are accepted only
// while idle. A one-cycle done pulse reports each channel reaching target.
// Optional build macro: LED_FADE_GAMMA_EN - squares brightness before PWM.
// Ports:
//   clk_25mhz  - clock
//   rst        - asynchronous active-high reset
//   cmd_valid  - command request
//   cmd_ready  - high while idle (command accepted when valid && ready)
//   cmd_ch     - target channel index
//   cmd_target - requested final brightness
//   cmd_rate   - step size minus one per fade tick
//   pause      - holds the prescaler, stopping fade progress
//   led        - registered PWM outputs
//   busy       - per channel, current brightness differs from target
//   done       - one-cycle pulse when a channel reaches target
//   done_ch    - channel index qualified by done
// ---------------------------------------------------------------------------
module led_fade_sequencer
  import led_fade_pkg::*;
#(
  parameter int N_CH     = N_CH_DEF,
  parameter int PWM_W    = PWM_W_DEF,
  parameter int STEP_DIV = 25000
) (
  input  logic                     clk_25mhz,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [$clog2(N_CH)-1:0]  cmd_ch,
  input  logic [PWM_W-1:0]         cmd_target,
  input  logic [RATE_W-1:0]        cmd_rate,
  input  logic                     pause,
  output logic [N_CH-1:0]          led,
  output logic [N_CH-1:0]          busy,
  output logic                     done,
  output logic [$clog2(N_CH)-1:0]  done_ch
);

  localparam int CH_W  = $clog2(N_CH);
  localparam int PSC_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int EXT_W = PWM_W + 1;

  localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(STEP_DIV - 1);
  localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(N_CH - 1);

  state_e                          state_r;
  logic [CH_W-1:0]                 scan_ch_r;
  logic [PSC_W-1:0]                psc_r;
  logic [N_CH-1:0][PWM_W-1:0]      cur_r;
  logic [N_CH-1:0][PWM_W-1:0]      tgt_r;
  logic [N_CH-1:0][RATE_W-1:0]     rate_r;
  logic                            done_r;
  logic [CH_W-1:0]                 done_ch_r;

  logic                            tick_s;
  logic [PWM_W-1:0]                sel_cur_s;
  logic [PWM_W-1:0]                sel_tgt_s;
  logic [RATE_W-1:0]               sel_rate_s;
  logic [EXT_W-1:0]                cur_w_s;
  logic [EXT_W-1:0]                tgt_w_s;
  logic [EXT_W-1:0]                step_w_s;
  logic [EXT_W-1:0]                up_w_s;
  logic [EXT_W-1:0]                dn_w_s;
  logic [PWM_W-1:0]                next_cur_s;
  logic                            arrive_s;
  logic [N_CH-1:0]                 busy_s;
  logic [N_CH-1:0][PWM_W-1:0]      eff_s;

  // Tick is suppressed while paused so the scan never starts mid-pause.
  assign tick_s = (!pause) && (psc_r == PSC_LAST);

  // Prescaler: counts 0..STEP_DIV-1, holding its value while paused.
  always_ff @(posedge clk_25mhz or posedge rst) begin
    if (rst) begin
      psc_r <= '0;
    end else if (pause) begin
      psc_r <= psc_r;
    end else if (psc_r == PSC_LAST) begin
      psc_r <= '0;
    end else begin
      psc_r <= psc_r + PSC_W'(1);
    end
  end

  // Selected-channel fade step; widened by one bit so neither the sum nor
  // the clamp comparison can wrap.
  always_comb begin
    sel_cur_s  = cur_r[scan_ch_r];
    sel_tgt_s  = tgt_r[scan_ch_r];
    sel_rate_s = rate_r[scan_ch_r];
    cur_w_s    = {1'b0, sel_cur_s};
    tgt_w_s    = {1'b0, sel_tgt_s};
    step_w_s   = {{(EXT_W - RATE_W){1'b0}}, sel_rate_s} + EXT_W'(1);
    up_w_s     = cur_w_s + step_w_s;
    dn_w_s     = cur_w_s - step_w_s;
    if (cur_w_s < tgt_w_s) begin
      if (up_w_s > tgt_w_s) begin
        next_cur_s = sel_tgt_s;
      end else begin
        next_cur_s = up_w_s[PWM_W-1:0];
      end
    end else if (cur_w_s > tgt_w_s) begin
      // Clamp test is done on the target side so dn_w_s is only used
      // when it is known not to underflow.
      if (cur_w_s <= (tgt_w_s + step_w_s)) begin
        next_cur_s = sel_tgt_s;
      end else begin
        next_cur_s = dn_w_s[PWM_W-1:0];
      end
    end else begin
      next_cur_s = sel_cur_s;
    end
    arrive_s = (sel_cur_s != sel_tgt_s) && (next_cur_s == sel_tgt_s);
  end

  // Sequencer FSM with command capture, channel scan and done reporting.
  always_ff @(posedge clk_25mhz or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      scan_ch_r <= '0;
      cur_r     <= '0;
      tgt_r     <= '0;
      rate_r    <= '0;
      done_r    <= 1'b0;
      done_ch_r <= '0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          // A command landing on the tick cycle is written before the scan
          // reads it on the following cycle.
          if (cmd_valid) begin
            tgt_r[cmd_ch]  <= cmd_target;
            rate_r[cmd_ch] <= cmd_rate;
          end
          if (tick_s) begin
            state_r   <= SCAN;
            scan_ch_r <= '0;
          end
        end
        SCAN: begin
          cur_r[scan_ch_r] <= next_cur_s;
          if (arrive_s) begin
            done_r    <= 1'b1;
            done_ch_r <= scan_ch_r;
          end
          if (scan_ch_r == LAST_CH) begin
            state_r <= IDLE;
          end else begin
            scan_ch_r <= scan_ch_r + CH_W'(1);
          end
        end
        default: begin
          state_r   <= IDLE;
          scan_ch_r <= '0;
        end
      endcase
    end
  end

  // Busy flags straight from the brightness registers.
  always_comb begin
    busy_s = '0;
    for (int i = 0; i < N_CH; i++) begin
      busy_s[i] = (cur_r[i] != tgt_r[i]);
    end
  end

`ifdef LED_FADE_GAMMA_EN
  // Squared gamma: keep the top PWM_W bits of cur*cur.
  always_comb begin
    logic [2*PWM_W-1:0] sq_v;
    eff_s = '0;
    sq_v  = '0;
    for (int i = 0; i < N_CH; i++) begin
      sq_v     = {{PWM_W{1'b0}}, cur_r[i]} * {{PWM_W{1'b0}}, cur_r[i]};
      eff_s[i] = sq_v[2*PWM_W-1:PWM_W];
    end
  end
`else
  // Linear brightness: PWM level equals current brightness.
  always_comb begin
    eff_s = cur_r;
  end
`endif

  led_pwm_core #(
    .N_CH  (N_CH),
    .PWM_W (PWM_W)
  ) u_pwm (
    .clk_25mhz (clk_25mhz),
    .rst       (rst),
    .eff       (eff_s),
    .led       (led)
  );

  assign cmd_ready = (state_r == IDLE);
  assign busy      = busy_s;
  assign done      = done_r;
  assign done_ch   = done_ch_r;

endmodule : led_fade_sequencer

// File: tb/tb_led_fade_sequencer.sv
// ---------------------------------------------------------------------------
// tb_led_fade_sequencer
// Directed bench for led_fade_sequencer with N_CH=8, PWM_W=10, STEP_DIV=16.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_led_fade_sequencer;

  logic        clk_25mhz;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_ch;
  logic [9:0]  cmd_target;
  logic [3:0]  cmd_rate;
  logic        pause;
  logic [7:0]  led;
  logic [7:0]  busy;
  logic        done;
  logic [2:0]  done_ch;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  int         dq_ch[$];
  int         dq_cyc[$];
  logic [1:0] dq_edge[$];
  logic [7:0] busy_prev;

  led_fade_sequencer #(
    .N_CH     (8),
    .PWM_W    (10),
    .STEP_DIV (16)
  ) dut (
    .clk_25mhz  (clk_25mhz),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_ch     (cmd_ch),
    .cmd_target (cmd_target),
    .cmd_rate   (cmd_rate),
    .pause      (pause),
    .led        (led),
    .busy       (busy),
    .done       (done),
    .done_ch    (done_ch)
  );

  // Clock generation, 10 time-unit period.
  initial begin
    clk_25mhz = 1'b0;
    forever #5 clk_25mhz = ~clk_25mhz;
  end

  // Cycle counter used to time-stamp done pulses.
  always @(posedge clk_25mhz) cyc <= cyc + 1;

  // Done monitor: records channel, time and busy edge of every pulse.
  always @(negedge clk_25mhz) begin
    if (done === 1'b1) begin
      dq_ch.push_back(int'(done_ch));
      dq_cyc.push_back(cyc);
      dq_edge.push_back({busy_prev[done_ch], busy[done_ch]});
    end
    busy_prev <= busy;
  end

  // Global watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Present a command and hold it until accepted; returns on the next falling edge.
  task automatic send_cmd(input int ch, input int tgt, input int rate);
    int n;
    logic [31:0] c, t, r;
    n = 0;
    c = ch; t = tgt; r = rate;
    cmd_valid  = 1'b1;
    cmd_ch     = c[2:0];
    cmd_target = t[9:0];
    cmd_rate   = r[3:0];
    while (!cmd_ready && n < 40) begin
      @(negedge clk_25mhz);
      n++;
    end
    check("cmd_accept", {31'd0, cmd_ready}, 32'd1);
    @(negedge clk_25mhz);
    cmd_valid = 1'b0;
  endtask

  // Wait for a scan to start (if not already running) and finish.
  task automatic wait_scan();
    int n;
    n = 0;
    while (cmd_ready && n < 40) begin
      @(negedge clk_25mhz);
      n++;
    end
    check("scan_start", {31'd0, cmd_ready}, 32'd0);
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge clk_25mhz);
      n++;
    end
    check("scan_end", {31'd0, cmd_ready}, 32'd1);
  endtask

  initial begin
    int cnt;
    int c0, c5, c6, c7;
    int exp5, exp6, exp7;

    rst        = 1'b1;
    cmd_valid  = 1'b0;
    cmd_ch     = 3'd0;
    cmd_target = 10'd0;
    cmd_rate   = 4'd0;
    pause      = 1'b0;

    // ---------------- reset state ----------------
    repeat (3) @(negedge clk_25mhz);
    check("rst_led",   {24'd0, led}, 32'd0);
    check("rst_busy",  {24'd0, busy}, 32'd0);
    check("rst_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_done",  {31'd0, done}, 32'd0);
    rst = 1'b0;
    dq_ch.delete(); dq_cyc.delete(); dq_edge.delete();
    cnt = 0;
    while (cmd_ready && cnt < 40) begin
      @(negedge clk_25mhz);
      cnt++;
    end
    check("first_tick_delay", cnt, 32'd16);
    wait_scan();
    check("rst_no_done", dq_ch.size(), 32'd0);
    check("rst_busy_after_scan", {24'd0, busy}, 32'd0);

    // ---------------- ramp up ch2 ----------------
    send_cmd(2, 100, 9);
    dq_ch.delete(); dq_cyc.delete(); dq_edge.delete();
    for (int k = 1; k <= 10; k++) begin
      wait_scan();
      check("ramp_cur2", {22'd0, dut.cur_r[2]}, 32'(10 * k));
      check("ramp_busy2", {31'd0, busy[2]}, (k < 10) ? 32'd1 : 32'd0);
    end
    check("ramp_done_count", dq_ch.size(), 32'd1);
    if (dq_ch.size() > 0) begin
      check("ramp_done_ch", dq_ch[0], 32'd2);
      check("ramp_busy_edge", {30'd0, dq_edge[0]}, 32'd2);
    end

    // ---------------- saturation ----------------
    send_cmd(0, 5, 15);
    wait_scan();
    check("sat_cur0_up", {22'd0, dut.cur_r[0]}, 32'd5);
    send_cmd(0, 0, 15);
    wait_scan();
    check("sat_cur0_floor", {22'd0, dut.cur_r[0]}, 32'd0);
    check("sat_busy0", {31'd0, busy[0]}, 32'd0);
    send_cmd(7, 1020, 15);
    repeat (64) wait_scan();
    check("sat_cur7_1020", {22'd0, dut.cur_r[7]}, 32'd1020);
    send_cmd(7, 1023, 15);
    wait_scan();
    check("sat_cur7_ceiling", {22'd0, dut.cur_r[7]}, 32'd1023);

    // ---------------- contention ----------------
    cnt = 0;
    while (cmd_ready && cnt < 40) begin
      @(negedge clk_25mhz);
      cnt++;
    end
    cmd_valid  = 1'b1;
    cmd_ch     = 3'd4;
    cmd_target = 10'd3;
    cmd_rate   = 4'd0;
    cnt = 0;
    while (!cmd_ready && cnt < 20) begin
      cnt++;
      @(negedge clk_25mhz);
    end
    check("cont_ready_low", cnt, 32'd8);
    check("cont_tgt_before", {22'd0, dut.tgt_r[4]}, 32'd0);
    @(negedge clk_25mhz);
    cmd_valid = 1'b0;
    check("cont_tgt_after", {22'd0, dut.tgt_r[4]}, 32'd3);
    check("cont_cur_kept", {22'd0, dut.cur_r[4]}, 32'd0);
    check("cont_busy4", {31'd0, busy[4]}, 32'd1);
    repeat (3) wait_scan();
    check("cont_cur4_final", {22'd0, dut.cur_r[4]}, 32'd3);

    // ---------------- pause ----------------
    send_cmd(5, 200, 0);
    wait_scan();
    check("pause_cur5_pre", {22'd0, dut.cur_r[5]}, 32'd1);
    pause = 1'b1;
    cnt = 0;
    repeat (80) begin
      @(negedge clk_25mhz);
      if (!cmd_ready) cnt++;
    end
    check("pause_no_scan", cnt, 32'd0);
    check("pause_cur5_frozen", {22'd0, dut.cur_r[5]}, 32'd1);
    pause = 1'b0;
    cnt = 0;
    while (cmd_ready && cnt < 40) begin
      @(negedge clk_25mhz);
      cnt++;
    end
    check("pause_resume_delay", cnt, 32'd8);
    wait_scan();
    check("pause_cur5_post", {22'd0, dut.cur_r[5]}, 32'd2);
    dq_ch.delete(); dq_cyc.delete(); dq_edge.delete();
    send_cmd(5, 2, 0);
    check("same_target_busy", {31'd0, busy[5]}, 32'd0);
    repeat (2) wait_scan();
    check("same_target_no_done", dq_ch.size(), 32'd0);

    // ---------------- PWM duty ----------------
    send_cmd(6, 256, 15);
    repeat (16) wait_scan();
    check("pwm_cur6", {22'd0, dut.cur_r[6]}, 32'd256);
    c0 = 0; c5 = 0; c6 = 0; c7 = 0;
    repeat (1024) begin
      @(negedge clk_25mhz);
      c0 += int'(led[0]);
      c5 += int'(led[5]);
      c6 += int'(led[6]);
      c7 += int'(led[7]);
    end
`ifdef LED_FADE_GAMMA_EN
    exp5 = 0; exp6 = 64; exp7 = 1022;
`else
    exp5 = 2; exp6 = 256; exp7 = 1023;
`endif
    check("pwm_duty_ch0", c0, 32'd0);
    check("pwm_duty_ch5", c5, exp5);
    check("pwm_duty_ch6", c6, exp6);
    check("pwm_duty_ch7", c7, exp7);

    // ---------------- multi-done ----------------
    wait_scan();
    dq_ch.delete(); dq_cyc.delete(); dq_edge.delete();
    send_cmd(1, 10, 15);
    send_cmd(3, 12, 15);
    wait_scan();
    check("multi_done_count", dq_ch.size(), 32'd2);
    if (dq_ch.size() == 2) begin
      check("multi_done_first", dq_ch[0], 32'd1);
      check("multi_done_second", dq_ch[1], 32'd3);
      check("multi_done_gap", dq_cyc[1] - dq_cyc[0], 32'd2);
    end

    // ---------------- reset mid-scan ----------------
    send_cmd(2, 0, 0);
    cnt = 0;
    while (cmd_ready && cnt < 40) begin
      @(negedge clk_25mhz);
      cnt++;
    end
    repeat (3) @(negedge clk_25mhz);
    rst = 1'b1;
    #1;
    check("mid_rst_led",   {24'd0, led}, 32'd0);
    check("mid_rst_busy",  {24'd0, busy}, 32'd0);
    check("mid_rst_done",  {31'd0, done}, 32'd0);
    check("mid_rst_ready", {31'd0, cmd_ready}, 32'd1);
    check("mid_rst_cur2",  {22'd0, dut.cur_r[2]}, 32'd0);
    @(negedge clk_25mhz);
    rst        = 1'b0;
    cmd_valid  = 1'b1;
    cmd_ch     = 3'd0;
    cmd_target = 10'd1;
    cmd_rate   = 4'd0;
    @(negedge clk_25mhz);
    cmd_valid = 1'b0;
    cnt = 1;
    while (cmd_ready && cnt < 40) begin
      @(negedge clk_25mhz);
      cnt++;
    end
    check("post_rst_tick_delay", cnt, 32'd16);
    @(negedge clk_25mhz);
    check("post_rst_done", {31'd0, done}, 32'd1);
    check("post_rst_done_ch", {29'd0, done_ch}, 32'd0);
    check("post_rst_cur0", {22'd0, dut.cur_r[0]}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule : tb_led_fade_sequencer
